// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared Simon sequence sizing defaults and colour encodings
package simon_pkg;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_DATA_W = 2;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } colour_t;

endpackage

// File: rtl/palindrome_datapath_if.sv
// rtl/palindrome_datapath_if.sv - controller <-> palindrome datapath signal bundle
interface palindrome_datapath_if #(
    parameter int DEPTH  = simon_pkg::DEF_DEPTH,
    parameter int DATA_W = simon_pkg::DEF_DATA_W
);
    localparam int AW = $clog2(DEPTH);

    logic              i_load;
    logic              i_select;
    logic              i_shift;
    logic              i_clear;
    logic              i_wr_en;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_a_ne_b;
    logic              o_front_ge_back;
    logic [AW:0]       o_seq_len;
    logic              o_full;
    logic              o_empty;
    logic              o_overflow;
    logic [AW-1:0]     o_front_idx;
    logic [AW-1:0]     o_back_idx;

    modport slave (
        input  i_load, i_select, i_shift, i_clear, i_wr_en, i_wr_data,
        output o_a_ne_b, o_front_ge_back, o_seq_len, o_full, o_empty,
               o_overflow, o_front_idx, o_back_idx
    );

    modport master (
        output i_load, i_select, i_shift, i_clear, i_wr_en, i_wr_data,
        input  o_a_ne_b, o_front_ge_back, o_seq_len, o_full, o_empty,
               o_overflow, o_front_idx, o_back_idx
    );

endinterface

// File: rtl/seq_mem.sv
// rtl/seq_mem.sv - DEPTH x DATA_W register file, one sync write port, two async read ports
module seq_mem #(
    parameter int DEPTH  = simon_pkg::DEF_DEPTH,
    parameter int DATA_W = simon_pkg::DEF_DATA_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clock,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr_a,
    output logic [DATA_W-1:0] o_rd_data_a,
    input  logic [AW-1:0]     i_rd_addr_b,
    output logic [DATA_W-1:0] o_rd_data_b
);

    // Contents are deliberately not reset; seq_len defines which entries are live.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data_a = r_mem[i_rd_addr_a];
    assign o_rd_data_b = r_mem[i_rd_addr_b];

endmodule

// File: rtl/palindrome_datapath.sv
// rtl/palindrome_datapath.sv - colour sequence store with front/back pointers walking inward
module palindrome_datapath
    import simon_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    palindrome_datapath_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     r_front;
    logic [AW-1:0]     r_back;
    logic [AW:0]       r_seq_len;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic              w_front_ge_back;
    logic              w_init;
    logic              w_shift;
    logic              w_wr_accept;
    logic [AW:0]       w_last;
    logic [AW-1:0]     w_init_back;
    logic [DATA_W-1:0] w_front_data;
    logic [DATA_W-1:0] w_back_data;

    assign w_full          = (r_seq_len == (AW+1)'(DEPTH));
    assign w_empty         = (r_seq_len == '0);
    assign w_front_ge_back = (r_front >= r_back);

    assign w_init      = bus.i_load & ~bus.i_select;
    // Shift stalls once the pointers meet or cross so back never underflows.
    assign w_shift     = bus.i_load & bus.i_select & bus.i_shift & ~w_front_ge_back;
    assign w_wr_accept = bus.i_wr_en & ~bus.i_clear & ~w_full;

    assign w_last      = r_seq_len - (AW+1)'(1);
    assign w_init_back = w_empty ? '0 : w_last[AW-1:0];

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_front <= '0;
            r_back  <= '0;
        end else if (w_init) begin
            r_front <= '0;
            r_back  <= w_init_back;
        end else if (w_shift) begin
            r_front <= r_front + AW'(1);
            r_back  <= r_back - AW'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_seq_len  <= '0;
            r_overflow <= 1'b0;
        end else if (bus.i_clear) begin
            r_seq_len  <= '0;
            r_overflow <= 1'b0;
        end else if (bus.i_wr_en) begin
            if (w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_seq_len <= r_seq_len + (AW+1)'(1);
            end
        end
    end

    seq_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_seq_mem (
        .i_clock     (i_clock),
        .i_wr_en     (w_wr_accept),
        .i_wr_addr   (r_seq_len[AW-1:0]),
        .i_wr_data   (bus.i_wr_data),
        .i_rd_addr_a (r_front),
        .o_rd_data_a (w_front_data),
        .i_rd_addr_b (r_back),
        .o_rd_data_b (w_back_data)
    );

    assign bus.o_a_ne_b        = (w_front_data != w_back_data);
    assign bus.o_front_ge_back = w_front_ge_back;
    assign bus.o_seq_len       = r_seq_len;
    assign bus.o_full          = w_full;
    assign bus.o_empty         = w_empty;
    assign bus.o_overflow      = r_overflow;
    assign bus.o_front_idx     = r_front;
    assign bus.o_back_idx      = r_back;

endmodule
